univ_shift_reg: RTL and testbench

//   Parametrised universal register and successor to the single-bit storage element.

---
 rtl/univ_shift_reg.sv | 97 +++++++++
 tb/tb_univ_shift_reg.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold, shift right/left, parallel load, with a saturating shift counter.
// Optional feature macro: USR_ROTATE_EN (rot=1 turns shifts into rotates).
module univ_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           d,
  input  logic                       sin_msb,
  input  logic                       sin_lsb,
  input  logic                       rot,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           q_b,
  output logic                       sout_lsb,
  output logic                       sout_msb,
  output logic [$clog2(WIDTH+1)-1:0] cnt,
  output logic                       drained
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic             w_rot;
  logic             w_in_msb;
  logic             w_in_lsb;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_shl;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    if (c == CNT_MAX) return c;
    else              return c + 1'b1;
  endfunction

`ifdef USR_ROTATE_EN
  assign w_rot = rot;
`else
  logic w_unused_rot;
  assign w_unused_rot = rot;
  assign w_rot        = 1'b0;
`endif

  // A rotate feeds the bit leaving the opposite end back in place of the serial input.
  assign w_in_msb = w_rot ? r_q[0]       : sin_msb;
  assign w_in_lsb = w_rot ? r_q[WIDTH-1] : sin_lsb;

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_shr = w_in_msb;
      assign w_shl = w_in_lsb;
    end else begin : g_wn
      assign w_shr = {w_in_msb, r_q[WIDTH-1:1]};
      assign w_shl = {r_q[WIDTH-2:0], w_in_lsb};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= RST_VAL;
      r_cnt <= '0;
    end else if (en) begin
      case (mode)
        MODE_HOLD: ;
        MODE_SHR: begin
          r_q   <= w_shr;
          r_cnt <= sat_inc(r_cnt);
        end
        MODE_SHL: begin
          r_q   <= w_shl;
          r_cnt <= sat_inc(r_cnt);
        end
        MODE_LOAD: begin
          r_q   <= d;
          r_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign q        = r_q;
  assign q_b      = ~r_q;
  assign sout_lsb = r_q[0];
  assign sout_msb = r_q[WIDTH-1];
  assign cnt      = r_cnt;
  assign drained  = (r_cnt == CNT_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (WIDTH=8): directed scenarios plus random traffic, scoreboard-checked.
module tb_univ_shift_reg;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);
`ifdef USR_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  d = '0;
  logic          sin_msb = 1'b0;
  logic          sin_lsb = 1'b0;
  logic          rot = 1'b0;
  logic [W-1:0]  q;
  logic [W-1:0]  q_b;
  logic          sout_lsb;
  logic          sout_msb;
  logic [CW-1:0] cnt;
  logic          drained;

  univ_shift_reg #(.WIDTH(W), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
    .sin_msb(sin_msb), .sin_lsb(sin_lsb), .rot(rot),
    .q(q), .q_b(q_b), .sout_lsb(sout_lsb), .sout_msb(sout_msb),
    .cnt(cnt), .drained(drained)
  );

  always #5 clk = ~clk;

  typedef struct { int q; int c; } exp_t;
  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;
  int m_q      = 0;
  int m_c      = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: register as an integer, shifts as arithmetic, counter as min(count+1, W).
  task automatic model_step(input bit r, input bit e, input int md, input int dv,
                            input bit sm, input bit sl, input bit rt);
    int in_bit;
    if (r) begin
      m_q = 0;
      m_c = 0;
    end else if (e) begin
      if (md == 1) begin
        in_bit = (ROT_EN && rt) ? (m_q % 2) : int'(sm);
        m_q = (m_q / 2) + in_bit * (1 << (W - 1));
        m_c = (m_c + 1 > W) ? W : m_c + 1;
      end else if (md == 2) begin
        in_bit = (ROT_EN && rt) ? (m_q / (1 << (W - 1))) : int'(sl);
        m_q = (m_q * 2 + in_bit) % (1 << W);
        m_c = (m_c + 1 > W) ? W : m_c + 1;
      end else if (md == 3) begin
        m_q = dv;
        m_c = 0;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit e, input logic [1:0] md, input logic [W-1:0] dv,
                       input bit sm, input bit sl, input bit rt);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; mode = md; d = dv; sin_msb = sm; sin_lsb = sl; rot = rt;
    @(posedge clk);
    model_step(r, e, int'(md), int'(dv), sm, sl, rt);
    x.q = m_q;
    x.c = m_c;
    sb.push_back(x);
  endtask

  // Monitor: outputs are presented every cycle, so each negedge consumes one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("q",        32'(q),        32'(e.q));
        check("q_b",      32'(q_b),      32'((~e.q) & 'hFF));
        check("sout_lsb", 32'(sout_lsb), 32'(e.q % 2));
        check("sout_msb", 32'(sout_msb), 32'(e.q / (1 << (W - 1))));
        check("cnt",      32'(cnt),      32'(e.c));
        check("drained",  32'(drained),  32'(e.c == W));
      end
    end
  end

  initial begin
    int waits;
    // Reset state
    cycle(1, 0, 2'b00, 8'h00, 0, 0, 0);
    // Load A5, then shift right with sin_msb=1 past saturation
    cycle(0, 1, 2'b11, 8'hA5, 0, 0, 0);
    for (int i = 0; i < 9; i++) cycle(0, 1, 2'b01, 8'h00, 1, 0, 0);
    // Load 81, shift left with sin_lsb=0 (rotate when enabled)
    cycle(0, 1, 2'b11, 8'h81, 0, 0, 0);
    cycle(0, 1, 2'b10, 8'h00, 0, 0, 1);
    cycle(0, 1, 2'b11, 8'h81, 0, 0, 0);
    cycle(0, 1, 2'b10, 8'h00, 0, 0, 0);
    // Rotate right variant from 81
    cycle(0, 1, 2'b11, 8'h81, 0, 0, 0);
    cycle(0, 1, 2'b01, 8'h00, 0, 1, 1);
    // Enable low blocks a load; reset beats an enabled load
    cycle(0, 0, 2'b11, 8'h3C, 1, 1, 0);
    cycle(0, 0, 2'b01, 8'h3C, 1, 1, 0);
    cycle(1, 1, 2'b11, 8'h3C, 0, 0, 0);
    // Three shifts then a load mid-drain
    for (int i = 0; i < 3; i++) cycle(0, 1, 2'b10, 8'h00, 1, 1, 0);
    cycle(0, 1, 2'b11, 8'h5A, 0, 0, 0);
    cycle(0, 1, 2'b00, 8'hFF, 1, 1, 0);
    // Random traffic, loads kept rare so the counter reaches saturation often
    for (int i = 0; i < 2000; i++) begin
      logic [1:0] md;
      md = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      cycle($urandom_range(0, 60) == 0, $urandom_range(0, 4) != 0, md,
            8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    waits = 0;
    while (sb.size() > 0 && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    @(posedge clk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
